// File: rtl/divider32bit_seq.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per cycle.
// Results and status are registered and only updated when a division completes.
module divider32bit_seq (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Quotient,
   output logic [31:0] Remainder,
   output logic        Busy,
   output logic        Done,
   output logic        DivByZero
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [31:0] rem;
   logic [31:0] quo;
   logic [5:0]  cnt;
   logic [32:0] partial;
   logic [32:0] diff;
   logic [31:0] rem_nxt;
   logic        qbit;
   logic        last_iter;
   logic        busy_nxt;
   logic        done_nxt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state <= IDLE;
         Busy  <= 1'b0;
         Done  <= 1'b0;
      end else begin
         state <= state_nxt;
         Busy  <= busy_nxt;
         Done  <= done_nxt;
      end
   end

   assign last_iter = (cnt == 6'd31);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (Start) state_nxt = (B != '0) ? RUN : DONE;
         RUN:  if (last_iter) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_nxt = (state_nxt != IDLE);
      done_nxt = (state_nxt == DONE);
   end

   // Partial remainder kept 33 bits wide so divisors above 2^31 cannot overflow.
   always_comb begin
      partial = {rem, dividend[31]};
      diff    = partial - {1'b0, divisor};
      qbit    = ~diff[32];
      rem_nxt = qbit ? diff[31:0] : partial[31:0];
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         dividend  <= '0;
         divisor   <= '0;
         rem       <= '0;
         quo       <= '0;
         cnt       <= '0;
         Quotient  <= '0;
         Remainder <= '0;
         DivByZero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  dividend <= A;
                  divisor  <= B;
                  rem      <= '0;
                  quo      <= '0;
                  cnt      <= '0;
                  if (B == '0) begin
                     Quotient  <= '1;
                     Remainder <= A;
                     DivByZero <= 1'b1;
                  end
               end
            end
            RUN: begin
               dividend <= {dividend[30:0], 1'b0};
               rem      <= rem_nxt;
               quo      <= {quo[30:0], qbit};
               cnt      <= cnt + 6'd1;
               if (last_iter) begin
                  Quotient  <= {quo[30:0], qbit};
                  Remainder <= rem_nxt;
                  DivByZero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider32bit_seq.sv
// Self-checking bench for divider32bit_seq: vector table, corner sequences and
// random operations, all compared through an expected-result queue.
module tb_divider32bit_seq;

   logic        Clk;
   logic        Rst;
   logic        Start;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] Quotient;
   logic [31:0] Remainder;
   logic        Busy;
   logic        Done;
   logic        DivByZero;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   divider32bit_seq dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .A         (A),
      .B         (B),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .Busy      (Busy),
      .Done      (Done),
      .DivByZero (DivByZero)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.a   = a;
      e.b   = b;
      e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.dbz = (b == 0);
      return e;
   endfunction

   // Drive Start for one edge (t0) and return sampling just after it.
   task automatic start_op(input exp_t e);
      @(negedge Clk);
      Start = 1'b1;
      A     = e.a;
      B     = e.b;
      sb.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   task automatic finish_op(input bit noisy);
      exp_t        e;
      int unsigned lat;
      int unsigned bcnt;
      e    = sb.pop_front();
      lat  = 0;
      bcnt = 0;
      while (!Done && lat < 40) begin
         if (Busy) bcnt++;
         if (noisy) begin
            Start = 1'($urandom_range(0, 1));
            A     = $urandom;
            B     = $urandom;
         end
         @(posedge Clk);
         #1;
         lat++;
      end
      if (noisy) Start = 1'b0;
      if (Busy) bcnt++;
      chk("done_latency", lat, (e.b == 0) ? 32'd0 : 32'd32);
      chk("busy_cycles", bcnt, (e.b == 0) ? 32'd1 : 32'd33);
      chk("quotient", Quotient, e.q);
      chk("remainder", Remainder, e.r);
      chk("divbyzero", {31'd0, DivByZero}, {31'd0, e.dbz});
   endtask

   task automatic do_op(input exp_t e, input bit noisy);
      start_op(e);
      Start = 1'b0;
      finish_op(noisy);
      @(posedge Clk);
      #1;
      chk("done_single", {31'd0, Done}, 32'd0);
      chk("idle_busy", {31'd0, Busy}, 32'd0);
      chk("hold_quotient", Quotient, e.q);
   endtask

   exp_t vecs[11];
   int   dones;

   initial begin
      vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
      vecs[2]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
      vecs[3]  = '{32'd1234,       32'd0,          32'hFFFF_FFFF,  32'd1234,       1'b1};
      vecs[4]  = '{32'd10,         32'd3,          32'd3,          32'd1,          1'b0};
      vecs[5]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
      vecs[6]  = '{32'd3,          32'd9,          32'd0,          32'd3,          1'b0};
      vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
      vecs[8]  = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE,  1'b0};
      vecs[9]  = '{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0};
      vecs[10] = '{32'd50,         32'd5,          32'd10,         32'd0,          1'b0};

      Rst   = 1'b0;
      Start = 1'b0;
      A     = '0;
      B     = '0;
      #12;
      chk("rst_quotient", Quotient, 32'd0);
      chk("rst_remainder", Remainder, 32'd0);
      chk("rst_flags", {29'd0, Busy, Done, DivByZero}, 32'd0);
      @(negedge Clk);
      Rst = 1'b1;

      for (int i = 0; i < 11; i++) do_op(vecs[i], 1'b0);

      // Start pulses and A/B noise during RUN must not disturb the result.
      do_op(vecs[10], 1'b1);

      // Start held high: ignored at the DONE edge, accepted on the next IDLE edge.
      start_op(model(32'd20, 32'd6));
      finish_op(1'b0);
      @(posedge Clk);
      #1;
      chk("held_idle_busy", {31'd0, Busy}, 32'd0);
      chk("held_idle_done", {31'd0, Done}, 32'd0);
      sb.push_back(model(32'd20, 32'd6));
      @(posedge Clk);
      #1;
      chk("held_accept_busy", {31'd0, Busy}, 32'd1);
      Start = 1'b0;
      finish_op(1'b0);
      @(posedge Clk);
      #1;

      // Reset in the middle of RUN aborts without a Done pulse.
      start_op(model(32'd50, 32'd5));
      Start = 1'b0;
      sb.delete();
      for (int i = 0; i < 15; i++) begin
         @(posedge Clk);
         #1;
      end
      #2;
      Rst = 1'b0;
      #1;
      chk("abort_quotient", Quotient, 32'd0);
      chk("abort_remainder", Remainder, 32'd0);
      chk("abort_flags", {29'd0, Busy, Done, DivByZero}, 32'd0);
      @(negedge Clk);
      @(negedge Clk);
      Rst   = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge Clk);
         #1;
         if (Done || Busy) dones++;
      end
      chk("abort_no_done", dones, 32'd0);
      do_op(model(32'd7, 32'd2), 1'b0);

      for (int i = 0; i < 1500; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         case ($urandom_range(0, 7))
            0: begin
               ra = $urandom;
               rb = '0;
            end
            1: begin
               ra = $urandom_range(0, 1000);
               rb = ra + 32'($urandom_range(1, 100));
            end
            default: begin
               ra = $urandom;
               rb = $urandom >> $urandom_range(0, 31);
            end
         endcase
         do_op(model(ra, rb), 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
